// File: rtl/stack_queue_pkg.sv
// Shared definitions for the stack/queue buffer: mode encodings, the
// per-cycle operation decode and the pointer wrap helpers.
package stack_pkg;

    localparam logic MODE_LIFO = 1'b0;
    localparam logic MODE_FIFO = 1'b1;

    // What the buffer actually does on a given edge after Full/Empty gating.
    typedef enum logic [1:0] {
        OP_IDLE = 2'd0,
        OP_PUSH = 2'd1,
        OP_POP  = 2'd2,
        OP_BOTH = 2'd3
    } op_e;

    // Advance a pointer, wrapping from depth-1 back to 0 (depth need not be 2^n).
    function automatic int ptr_inc(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    // Step a pointer back, wrapping from 0 to depth-1.
    function automatic int ptr_dec(input int ptr, input int depth);
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/stack_queue_if.sv
// Producer/consumer port bundle of the stack/queue buffer.
//
// Handshake: there is no ready/valid back-pressure. Push writes Data_In on
// the edge it is sampled high unless Full (then Overflow is set); Pop reads
// one entry unless Empty (then Underflow is set). A successful pop updates
// Data_Out on that edge and raises Out_Valid for exactly one cycle. Full and
// Empty are the only throttles the producer/consumer must respect.
interface stack_queue_if #(
    parameter int STACK_DEPTH = 8,
    parameter int STACK_WIDTH = 4
);
    localparam int CW = $clog2(STACK_DEPTH + 1);

    logic                   Mode;
    logic                   Push;
    logic                   Pop;
    logic [STACK_WIDTH-1:0] Data_In;
    logic                   Clr_Err;
    logic [STACK_WIDTH-1:0] Data_Out;
    logic                   Out_Valid;
    logic [CW-1:0]          Count;
    logic                   Full;
    logic                   Empty;
    logic                   Almost_Full;
    logic                   Overflow;
    logic                   Underflow;
    logic                   mode_q;      // latched operating mode, for observation

    modport master (
        output Mode, Push, Pop, Data_In, Clr_Err,
        input  Data_Out, Out_Valid, Count, Full, Empty, Almost_Full,
               Overflow, Underflow, mode_q
    );

    modport slave (
        input  Mode, Push, Pop, Data_In, Clr_Err,
        output Data_Out, Out_Valid, Count, Full, Empty, Almost_Full,
               Overflow, Underflow, mode_q
    );

endinterface

// File: rtl/stack_queue_mem.sv
// Entry storage: register array with one synchronous write port and one
// combinational read port. Contents are deliberately not reset.
module stack_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the addressed entry on the rising edge.
    always_ff @(posedge clk) begin
        if (we) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/stack_queue.sv
// LIFO/FIFO buffer with run-time mode, simultaneous push+pop, occupancy
// count, almost-full and sticky error flags. Pointers, count, mode latch,
// flags and the output register live here; storage is in stack_mem.
module stack_queue
    import stack_pkg::*;
#(
    parameter int STACK_DEPTH = 8,
    parameter int STACK_WIDTH = 4,
    parameter int AFULL_LEVEL = STACK_DEPTH - 1
) (
    input  logic         Clk,
    input  logic         Rst,
    stack_queue_if.slave bus
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 2) ? $clog2(STACK_DEPTH) : 1;

    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [CW-1:0]          count_q;
    logic                   mode_q;
    logic [STACK_WIDTH-1:0] dout_q;
    logic                   valid_q;
    logic                   ovf_q;
    logic                   udf_q;

    logic                   empty;
    logic                   full;
    logic [PW-1:0]          top_ptr;
    logic [PW-1:0]          wr_next;
    logic [PW-1:0]          rd_next;
    op_e                    op;
    logic                   ovf_evt;
    logic                   udf_evt;
    logic                   mem_we;
    logic [PW-1:0]          mem_wr_addr;
    logic [PW-1:0]          mem_rd_addr;
    logic [STACK_WIDTH-1:0] mem_rd_data;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(STACK_DEPTH));
    assign top_ptr = PW'(ptr_dec(int'(wr_ptr), STACK_DEPTH));
    assign wr_next = PW'(ptr_inc(int'(wr_ptr), STACK_DEPTH));
    assign rd_next = PW'(ptr_inc(int'(rd_ptr), STACK_DEPTH));

    // Decide what this edge does; push+pop on empty degrades to a push.
    always_comb begin
        op = OP_IDLE;
        if (bus.Push && bus.Pop && !empty)   op = OP_BOTH;
        else if (bus.Push && !full)          op = OP_PUSH;
        else if (bus.Pop && !bus.Push && !empty) op = OP_POP;
    end

    assign ovf_evt = bus.Push && !bus.Pop && full;
    assign udf_evt = bus.Pop && !bus.Push && empty;

    // Reads only happen while non-empty, so the latched mode is the right one.
    assign mem_rd_addr = (mode_q == MODE_LIFO) ? top_ptr : rd_ptr;
    assign mem_we      = (op == OP_PUSH) || (op == OP_BOTH);
    // A LIFO push+pop replaces the current top in place.
    assign mem_wr_addr = (op == OP_BOTH && mode_q == MODE_LIFO) ? top_ptr : wr_ptr;

    stack_mem #(
        .DEPTH (STACK_DEPTH),
        .WIDTH (STACK_WIDTH),
        .AW    (PW)
    ) u_mem (
        .clk     (Clk),
        .we      (mem_we),
        .wr_addr (mem_wr_addr),
        .wr_data (bus.Data_In),
        .rd_addr (mem_rd_addr),
        .rd_data (mem_rd_data)
    );

    // Pointer, count, mode, output and flag state; reset dominates everything.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            mode_q  <= MODE_LIFO;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            if (empty) mode_q <= bus.Mode;
            valid_q <= (op == OP_POP) || (op == OP_BOTH);
            if ((op == OP_POP) || (op == OP_BOTH)) dout_q <= mem_rd_data;

            case (op)
                OP_PUSH: begin
                    wr_ptr  <= wr_next;
                    count_q <= count_q + CW'(1);
                end
                OP_POP: begin
                    if (mode_q == MODE_LIFO) wr_ptr <= top_ptr;
                    else                     rd_ptr <= rd_next;
                    count_q <= count_q - CW'(1);
                end
                OP_BOTH: begin
                    if (mode_q == MODE_FIFO) begin
                        wr_ptr <= wr_next;
                        rd_ptr <= rd_next;
                    end
                end
                default: ;
            endcase

            // A new error on the same edge as Clr_Err keeps the flag set.
            ovf_q <= ovf_evt || (ovf_q && !bus.Clr_Err);
            udf_q <= udf_evt || (udf_q && !bus.Clr_Err);
        end
    end

    assign bus.Data_Out    = dout_q;
    assign bus.Out_Valid   = valid_q;
    assign bus.Count       = count_q;
    assign bus.Full        = full;
    assign bus.Empty       = empty;
    assign bus.Almost_Full = (int'(count_q) >= AFULL_LEVEL);
    assign bus.Overflow    = ovf_q;
    assign bus.Underflow   = udf_q;
    assign bus.mode_q      = mode_q;

endmodule

// File: tb/tb_stack_queue.sv
// Bench for stack_queue at depth 4, width 4: table of hand-derived vectors,
// directed multi-cycle sequences and a random phase, all checked against a
// queue-based reference model and an expected-data scoreboard.
module tb_stack_queue;

    localparam int D = 4;
    localparam int W = 4;

    logic Clk;
    logic Rst;

    stack_queue_if #(.STACK_DEPTH(D), .STACK_WIDTH(W)) bus ();

    stack_queue #(.STACK_DEPTH(D), .STACK_WIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus.slave)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0] mdl[$];
    logic [W-1:0] exp_q[$];
    logic         m_mode;
    logic         m_ovf;
    logic         m_udf;
    logic         m_valid;
    logic [W-1:0] m_dout;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model after an edge.
    task automatic check_outputs();
        logic [W-1:0] e;
        check("count", int'(bus.Count), mdl.size());
        check("empty", int'(bus.Empty), int'(mdl.size() == 0));
        check("full", int'(bus.Full), int'(mdl.size() == D));
        check("afull", int'(bus.Almost_Full), int'(mdl.size() >= D - 1));
        check("overflow", int'(bus.Overflow), int'(m_ovf));
        check("underflow", int'(bus.Underflow), int'(m_udf));
        check("out_valid", int'(bus.Out_Valid), int'(m_valid));
        check("data_out_hold", int'(bus.Data_Out), int'(m_dout));
        if (bus.Out_Valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_spurious", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("scoreboard_data", int'(bus.Data_Out), int'(e));
            end
        end else if (m_valid && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end
    endtask

    // Drive one cycle of stimulus, advance the model, then check.
    task automatic drive_cycle(input bit push, input bit pop, input logic [W-1:0] din,
                               input bit mode, input bit clr);
        bit m_empty;
        bit m_full;
        logic [W-1:0] d;
        m_empty = (mdl.size() == 0);
        m_full  = (mdl.size() == D);
        if (m_empty) m_mode = mode;
        m_valid = 1'b0;
        if (push && pop && !m_empty) begin
            if (m_mode == 1'b0) begin
                d = mdl[mdl.size() - 1];
                mdl[mdl.size() - 1] = din;
            end else begin
                d = mdl.pop_front();
                mdl.push_back(din);
            end
            m_valid = 1'b1;
        end else if (push && !m_full) begin
            mdl.push_back(din);
        end else if (pop && !push && !m_empty) begin
            if (m_mode == 1'b0) d = mdl.pop_back();
            else                d = mdl.pop_front();
            m_valid = 1'b1;
        end
        if (m_valid) begin
            m_dout = d;
            exp_q.push_back(d);
        end
        m_ovf = (push && !pop && m_full) || (m_ovf && !clr);
        m_udf = (pop && !push && m_empty) || (m_udf && !clr);

        bus.Push    = push;
        bus.Pop     = pop;
        bus.Data_In = din;
        bus.Mode    = mode;
        bus.Clr_Err = clr;
        @(posedge Clk);
        #1;
        check_outputs();
    endtask

    // Reset with arbitrary concurrent operation; reset must win.
    task automatic do_reset(input bit push, input bit pop, input bit clr);
        bus.Push    = push;
        bus.Pop     = pop;
        bus.Data_In = 4'hA;
        bus.Mode    = 1'b1;
        bus.Clr_Err = clr;
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        bus.Push = 1'b0;
        bus.Pop  = 1'b0;
        bus.Clr_Err = 1'b0;
        mdl.delete();
        exp_q.delete();
        m_mode = 1'b0; m_ovf = 1'b0; m_udf = 1'b0; m_valid = 1'b0; m_dout = '0;
        check("rst_count", int'(bus.Count), 0);
        check("rst_empty", int'(bus.Empty), 1);
        check("rst_full", int'(bus.Full), 0);
        check("rst_afull", int'(bus.Almost_Full), 0);
        check("rst_data_out", int'(bus.Data_Out), 0);
        check("rst_out_valid", int'(bus.Out_Valid), 0);
        check("rst_overflow", int'(bus.Overflow), 0);
        check("rst_underflow", int'(bus.Underflow), 0);
        check("rst_mode", int'(bus.mode_q), 0);
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        bit         push;
        bit         pop;
        logic [3:0] din;
        int         exp_count;
        logic [3:0] exp_dout;
        bit         exp_valid;
    } vec_t;

    vec_t tbl[12];

    initial begin
        // LIFO push 1,2,3 then pop x3
        tbl[0]  = '{1, 0, 4'd1, 1, 4'd0, 0};
        tbl[1]  = '{1, 0, 4'd2, 2, 4'd0, 0};
        tbl[2]  = '{1, 0, 4'd3, 3, 4'd0, 0};
        tbl[3]  = '{0, 1, 4'd0, 2, 4'd3, 1};
        tbl[4]  = '{0, 1, 4'd0, 1, 4'd2, 1};
        tbl[5]  = '{0, 1, 4'd0, 0, 4'd1, 1};
        // fill to Full, overflow push, then pop returns the top
        tbl[6]  = '{1, 0, 4'd1, 1, 4'd1, 0};
        tbl[7]  = '{1, 0, 4'd2, 2, 4'd1, 0};
        tbl[8]  = '{1, 0, 4'd3, 3, 4'd1, 0};
        tbl[9]  = '{1, 0, 4'd4, 4, 4'd1, 0};
        tbl[10] = '{1, 0, 4'd9, 4, 4'd1, 0};
        tbl[11] = '{0, 1, 4'd0, 3, 4'd4, 1};

        bus.Push = 1'b0; bus.Pop = 1'b0; bus.Data_In = '0;
        bus.Mode = 1'b0; bus.Clr_Err = 1'b0;
        Rst = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        do_reset(1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 12; i++) begin
            drive_cycle(tbl[i].push, tbl[i].pop, tbl[i].din, 1'b0, 1'b0);
            check($sformatf("tbl%0d_count", i), int'(bus.Count), tbl[i].exp_count);
            check($sformatf("tbl%0d_dout", i), int'(bus.Data_Out), int'(tbl[i].exp_dout));
            check($sformatf("tbl%0d_valid", i), int'(bus.Out_Valid), int'(tbl[i].exp_valid));
        end
        check("tbl_overflow_set", int'(bus.Overflow), 1);

        // drain the remaining 3 (LIFO), clear the overflow
        for (int i = 0; i < 3; i++) drive_cycle(0, 1, 4'd0, 1'b0, 1'b0);
        drive_cycle(0, 0, 4'd0, 1'b0, 1'b1);
        check("clr_overflow", int'(bus.Overflow), 0);

        // FIFO with pointer wrap: push 1..4, pop 2, push 5,6, pop 4
        for (int i = 1; i <= 4; i++) drive_cycle(1, 0, 4'(i), 1'b1, 1'b0);
        drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        check("fifo_first", int'(bus.Data_Out), 1);
        drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        drive_cycle(1, 0, 4'd5, 1'b1, 1'b0);
        drive_cycle(1, 0, 4'd6, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        check("fifo_last", int'(bus.Data_Out), 6);
        check("fifo_empty", int'(bus.Empty), 1);

        // LIFO push+pop: top=7, Data_In=8 -> out 7, count same, next pop 8
        drive_cycle(1, 0, 4'd7, 1'b0, 1'b0);
        drive_cycle(1, 1, 4'd8, 1'b0, 1'b0);
        check("lifo_both_out", int'(bus.Data_Out), 7);
        check("lifo_both_count", int'(bus.Count), 1);
        drive_cycle(0, 1, 4'd0, 1'b0, 1'b0);
        check("lifo_both_next", int'(bus.Data_Out), 8);

        // FIFO full push+pop: head=1, push 9 -> out 1, count 4, no overflow
        for (int i = 1; i <= 4; i++) drive_cycle(1, 0, 4'(i), 1'b1, 1'b0);
        drive_cycle(1, 1, 4'd9, 1'b1, 1'b0);
        check("fifo_full_both_out", int'(bus.Data_Out), 1);
        check("fifo_full_both_count", int'(bus.Count), 4);
        check("fifo_full_both_ovf", int'(bus.Overflow), 0);
        for (int i = 0; i < 4; i++) drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        check("fifo_full_drain_tail", int'(bus.Data_Out), 9);

        // push+pop on empty behaves as push only
        drive_cycle(1, 1, 4'd5, 1'b0, 1'b0);
        check("empty_both_count", int'(bus.Count), 1);
        check("empty_both_valid", int'(bus.Out_Valid), 0);
        check("empty_both_udf", int'(bus.Underflow), 0);
        drive_cycle(0, 1, 4'd0, 1'b0, 1'b0);

        // underflow: Data_Out holds, then Clr_Err; clear+new error keeps flag
        drive_cycle(0, 1, 4'd0, 1'b0, 1'b0);
        check("udf_set", int'(bus.Underflow), 1);
        check("udf_hold_data", int'(bus.Data_Out), 5);
        drive_cycle(0, 1, 4'd0, 1'b0, 1'b1);
        check("udf_clr_and_err", int'(bus.Underflow), 1);
        drive_cycle(0, 0, 4'd0, 1'b0, 1'b1);
        check("udf_clr", int'(bus.Underflow), 0);

        // mode change while non-empty ignored until drained
        drive_cycle(1, 0, 4'd1, 1'b0, 1'b0);
        drive_cycle(1, 0, 4'd2, 1'b0, 1'b0);
        drive_cycle(1, 0, 4'd3, 1'b1, 1'b0);
        check("mode_still_lifo", int'(bus.mode_q), 0);
        drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        check("mode_lifo_pop", int'(bus.Data_Out), 3);
        drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        drive_cycle(0, 0, 4'd0, 1'b1, 1'b0);
        check("mode_now_fifo", int'(bus.mode_q), 1);

        // overflow with concurrent Clr_Err keeps the flag
        for (int i = 0; i < 4; i++) drive_cycle(1, 0, 4'(i + 10), 1'b1, 1'b0);
        drive_cycle(1, 0, 4'd15, 1'b1, 1'b1);
        check("ovf_clr_and_err", int'(bus.Overflow), 1);

        // reset mid-operation with a push on the same edge
        drive_cycle(0, 1, 4'd0, 1'b1, 1'b0);
        do_reset(1'b1, 1'b0, 1'b0);

        // random traffic, occasional resets
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 60) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                drive_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, 15)),
                            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
            end
        end

        // drain and confirm the scoreboard is balanced
        for (int i = 0; i < D; i++) drive_cycle(0, (mdl.size() != 0), 4'd0, 1'b0, 1'b0);
        check("scoreboard_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
